// File: rtl/te_radio_pkg.sv
// Shared types and default timing constants for the radio enable synchronizer.
package te_radio_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    EN_ONLY = 2'd1,
    EN_RX   = 2'd2,
    DRAIN   = 2'd3
  } lane_state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 4;

endpackage

// File: rtl/te_sync_filter.sv
// One async request: SYNC_STAGES flop synchronizer, then a FILT_CYCLES stability filter.
// Latency SYNC_STAGES+FILT_CYCLES-1 edges from sample to q_filt; no backpressure.
module te_sync_filter
  import te_radio_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic ck,
  input  logic arst,
  input  logic d_async,
  output logic q_filt
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f;
  logic [CW-1:0]          cnt;

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any return of s to f before the count completes restarts the count.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (s == f) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      f   <= s;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign q_filt = f;

endmodule

// File: rtl/te_radio_en_sync.sv
// Syncs/filters per-lane radio enable and RX-enable requests, sequences them per lane.
// Latency SYNC_STAGES+FILT_CYCLES edges to the state register; outputs decoded from state, no backpressure.
module te_radio_en_sync
  import te_radio_pkg::*;
#(
  parameter int BIT_WIDTH   = 2,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic                 ck,
  input  logic                 arst,
  input  logic                 isolateM1M3,
  input  logic [BIT_WIDTH-1:0] radioEnableAsync,
  input  logic [BIT_WIDTH-1:0] radioRxEnAsync,
  output logic [BIT_WIDTH-1:0] radioEnableSynced,
  output logic [BIT_WIDTH-1:0] radioRxEnSynced,
  output logic [BIT_WIDTH-1:0] stateChg
);

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_lane
    logic        fe;
    logic        fr;
    logic        chg_q;
    lane_state_t state;
    lane_state_t state_nxt;

    te_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_en_filt (
      .ck      (ck),
      .arst    (arst),
      .d_async (radioEnableAsync[i]),
      .q_filt  (fe)
    );

    te_sync_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_rx_filt (
      .ck      (ck),
      .arst    (arst),
      .d_async (radioRxEnAsync[i]),
      .q_filt  (fr)
    );

    always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
        state <= OFF;
        chg_q <= 1'b0;
      end else begin
        state <= state_nxt;
        chg_q <= (state_nxt != state);
      end
    end

    // EN_ONLY always sits between OFF and EN_RX, and DRAIN between EN_RX and OFF,
    // so rx can only ever be high inside an enable window.
    always_comb begin
      state_nxt = state;
      case (state)
        OFF:     if (fe) state_nxt = EN_ONLY;
        EN_ONLY: begin
          if (!fe)     state_nxt = OFF;
          else if (fr) state_nxt = EN_RX;
        end
        EN_RX: begin
          if (!fe)      state_nxt = DRAIN;
          else if (!fr) state_nxt = EN_ONLY;
        end
        DRAIN:   state_nxt = OFF;
        default: state_nxt = OFF;
      endcase
      if (isolateM1M3) state_nxt = OFF;
    end

    assign radioEnableSynced[i] = !isolateM1M3 && (state != OFF);
    assign radioRxEnSynced[i]   = !isolateM1M3 && (state == EN_RX);
    assign stateChg[i]          = chg_q;
  end

endmodule

// File: doc/te_radio_en_sync.md
Name: te_radio_en_sync

Overview:
- Upstream stage of the TimingEngine S2→S4 register stage. Receives asynchronous per-lane radio enable and RX-enable requests and synchronizes them into the ck domain.
- Glitch-filters each request. A per-lane sequencing FSM then produces radioEnableSynced / radioRxEnSynced for the S2 interface.
- Guarantees RX-enable is never high unless enable is high, and enforces power-up/power-down ordering.

Parameters:
- BIT_WIDTH, 2: number of radio lanes. Must match the downstream S4 register stage.
- SYNC_STAGES, 2: synchronizer flop depth, range 2..4.
- FILT_CYCLES, 4: consecutive stable cycles required before a synchronized change is accepted, range 1..15.

Ports:
- ck  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- isolateM1M3  in  1  isolation request. Clamps outputs and forces lanes off.
- radioEnableAsync  in  BIT_WIDTH  asynchronous enable request per lane.
- radioRxEnAsync  in  BIT_WIDTH  asynchronous RX-enable request per lane.
- radioEnableSynced  out  BIT_WIDTH  synchronized, sequenced enable (drives uin_TimingEngineS2).
- radioRxEnSynced  out  BIT_WIDTH  synchronized, sequenced RX-enable (drives uin_TimingEngineS2).
- stateChg  out  BIT_WIDTH  1-cycle pulse when the lane FSM changes state.

Behaviour:
- Reset (arst high): all sync flops, filtered values, counters and lane FSMs clear. FSMs go to OFF. All outputs are 0.
- Per signal (2·BIT_WIDTH instances), synchronizer:
  - SYNC_STAGES flop chain; the last stage is s.
- Per signal, filter:
  - Registers f (filtered value) and cnt.
  - If s==f: cnt<=0.
  - If s!=f and cnt<FILT_CYCLES-1: cnt<=cnt+1.
  - If s!=f and cnt==FILT_CYCLES-1: f<=s, cnt<=0.
  - Any return of s to f before acceptance resets cnt, so a glitch shorter than FILT_CYCLES is dropped.
  - cnt width is $clog2(FILT_CYCLES+1).
- Latency: a change on an async input sampled at edge 0 reaches the FSM state register at edge SYNC_STAGES+FILT_CYCLES. This is 6 edges with the defaults.
- Lane FSM inputs: fe = filtered enable, fr = filtered RX-enable.
- Lane FSM states and transitions:
  - OFF: outputs en=0, rx=0. fe=1 → EN_ONLY.
  - EN_ONLY: en=1, rx=0. fe=0 → OFF; else fr=1 → EN_RX. The lane always spends at least 1 cycle here.
  - EN_RX: en=1, rx=1. fe=0 → DRAIN; else fr=0 → EN_ONLY.
  - DRAIN: en=1, rx=0. Always → OFF next cycle. Rx therefore drops one cycle before enable.
- Simultaneous fe and fr rise in OFF: OFF → EN_ONLY → EN_RX. rx rises 1 cycle after en.
- fr=1 with fe=0: ignored. The lane stays OFF.
- Outputs are decoded from the state register only, with no combinational path from the async inputs.
- Isolation (isolateM1M3=1):
  - Outputs are gated to 0 combinationally in the same cycle.
  - Every lane FSM is forced to OFF at the next edge and held there while isolation persists.
  - Synchronizers and filters keep running.
  - After release, lanes re-sequence from OFF, so en rises first and rx at least 1 cycle later.
- stateChg[i]: registered. High for exactly 1 cycle after any state transition of lane i, including forced transitions to OFF.
- Lanes are fully independent.
- Reset asserted mid-sequence: outputs clear immediately (asynchronously). On release the FSMs restart from OFF with filters at 0.

Decomposition:
- Shared package te_radio_pkg holds:
  - typedef enum logic [1:0] lane_state_t {OFF, EN_ONLY, EN_RX, DRAIN};
  - default constants for SYNC_STAGES and FILT_CYCLES.
- Sub-module te_sync_filter (parameters SYNC_STAGES, FILT_CYCLES; ports ck, arst, d_async, q_filt).
- Top level instantiates 2·BIT_WIDTH te_sync_filter instances and a generate loop of BIT_WIDTH lane FSMs.

Test Plan:
- Reset then raise radioEnableAsync[0] → radioEnableSynced[0]=1 exactly 6 edges after the sampling edge, with stateChg[0] pulsing once. Lane 1 stays 0.
- Raise radioEnableAsync[1] and radioRxEnAsync[1] together → en[1] rises at edge 6 and rx[1] at edge 7. radioRxEnSynced is never 1 while radioEnableSynced is 0.
- A 3-cycle high glitch on radioEnableAsync[0] → no output change. A 4-cycle stable pulse → en[0] asserts.
- From EN_RX on lane 0, drop radioEnableAsync[0] → rx[0]=0 one cycle before en[0]=0, with two stateChg pulses (→DRAIN, →OFF).
- Both lanes in EN_RX, assert isolateM1M3 → all outputs 0 in the same cycle and FSMs reach OFF next edge. Release it → en=1 then rx=1 one cycle later on both lanes.
- Assert arst while lane 0 is in DRAIN → outputs 0 immediately. Release arst with inputs held high → full 6-cycle relock to EN_ONLY, then EN_RX one cycle later.
